mm_trg_arbiter: RTL and testbench

//  Merges the triggered outputs of NUM_CH minimum-trigger channels into one AXI4-Stream.
//  - Arbitrates at frame start, then forwards the granted channel's beats until its trigger

---
 rtl/mm_trg_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mm_trg_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_trg_arbiter.sv
// mm_trg_arbiter: merges triggered minimum-trigger channels into one AXI4-Stream.
// Each frame is a header beat, the granted channel's data beats, and a footer (TLAST).
// Starts that arrive while a frame is in flight are dropped and counted.
// Build option MM_ARB_FIXED_PRIO_EN: lowest channel index wins instead of round-robin.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a start while EXEC_STATE is TRG
// ST_HDR     | header beat on the output, first data beat in the pipe
// ST_DATA    | forwarding data beats of the granted channel
// ST_FTR     | footer on the output, held until TREADY

module mm_trg_arbiter #(
    parameter int NUM_CH               = 4,
    parameter int TIME_STAMP_WIDTH     = 44,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int MAX_BEATS            = 256
) (
    input  logic                                   AXIS_ACLK,
    input  logic                                   AXIS_ARESETN,
    input  logic [1:0]                             EXEC_STATE,
    input  logic [NUM_CH-1:0]                      CH_TRIGGERED,
    input  logic [NUM_CH*S_AXIS_TDATA_WIDTH-1:0]   CH_DATA,
    input  logic [NUM_CH*TIME_STAMP_WIDTH-1:0]     CH_TIME_STAMP,
    input  logic [NUM_CH*ADC_RESOLUTION_WIDTH-1:0] CH_BASELINE,
    output logic [S_AXIS_TDATA_WIDTH-1:0]          M_AXIS_TDATA,
    output logic                                   M_AXIS_TVALID,
    output logic                                   M_AXIS_TLAST,
    input  logic                                   M_AXIS_TREADY,
    output logic                                   BUSY,
    output logic [31:0]                            DROP_COUNT
);

    localparam int DW      = S_AXIS_TDATA_WIDTH;
    localparam int TSW     = TIME_STAMP_WIDTH;
    localparam int BLW     = ADC_RESOLUTION_WIDTH;
    localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HDR_PAD = DW - 12 - BLW - TSW;
    localparam int FTR_PAD = DW - 30;
    localparam logic [15:0] MAX_CNT = 16'(MAX_BEATS);
    localparam logic [1:0]  EXEC_TRG = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_FTR  = 2'd3;

    logic [1:0]        state;
    logic [NUM_CH-1:0] trg_q;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] drop_vec;
    logic [CW-1:0]     grant_idx;
    logic              grant_vld;
    logic [CW-1:0]     g_q;
`ifndef MM_ARB_FIXED_PRIO_EN
    logic [CW-1:0]     rr_ptr;
`endif
    logic [DW-1:0]     pipe;
    logic              pipe_vld;
    logic [15:0]       beat_cnt;
    logic              lost_q;
    logic              lost_now;
    logic [5:0]        drop_num;
    logic [32:0]       drop_sum;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              busy_q;
    logic [31:0]       drop_count_q;

    function automatic logic [DW-1:0] make_ftr(input logic [3:0] ch, input logic [15:0] cnt,
                                               input logic trunc, input logic lost);
        return {8'h55, ch, cnt, trunc, lost, {FTR_PAD{1'b0}}};
    endfunction

    // start detection, grant selection and drop vector
    always_comb begin
`ifndef MM_ARB_FIXED_PRIO_EN
        int idx;
        idx = 0;
`endif
        start     = CH_TRIGGERED & ~trg_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
`ifdef MM_ARB_FIXED_PRIO_EN
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (start[i]) grant_idx = CW'(i);
        end
        grant_vld = |start;
`else
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_vld && start[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(idx);
            end
        end
`endif
        if (state != ST_IDLE || EXEC_STATE != EXEC_TRG) grant_vld = 1'b0;
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
        drop_vec = start & ~grant_oh;
    end

    // dropped-start popcount and saturating sum; lost flag including the beat now visible
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop_num = drop_num + {5'b0, drop_vec[i]};
        end
        drop_sum = {1'b0, drop_count_q} + {27'b0, drop_num};
        lost_now = lost_q | (m_tvalid & ~m_tlast & ~M_AXIS_TREADY);
    end

    // frame sequencing, output beat register and drop counter
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state        <= ST_IDLE;
            trg_q        <= '0;
            g_q          <= '0;
`ifndef MM_ARB_FIXED_PRIO_EN
            rr_ptr       <= '0;
`endif
            pipe         <= '0;
            pipe_vld     <= 1'b0;
            beat_cnt     <= '0;
            lost_q       <= 1'b0;
            m_tdata      <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            busy_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            trg_q        <= CH_TRIGGERED;
            drop_count_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        state    <= ST_HDR;
                        busy_q   <= 1'b1;
                        g_q      <= grant_idx;
`ifndef MM_ARB_FIXED_PRIO_EN
                        rr_ptr   <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
`endif
                        pipe     <= CH_DATA[int'(grant_idx)*DW +: DW];
                        pipe_vld <= 1'b1;
                        beat_cnt <= '0;
                        lost_q   <= 1'b0;
                        m_tdata  <= {8'hAA, 4'(grant_idx),
                                     CH_BASELINE[int'(grant_idx)*BLW +: BLW],
                                     CH_TIME_STAMP[int'(grant_idx)*TSW +: TSW],
                                     {HDR_PAD{1'b0}}};
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                    end
                end
                ST_HDR, ST_DATA: begin
                    lost_q <= lost_now;
                    if (pipe_vld && beat_cnt != MAX_CNT) begin
                        state    <= ST_DATA;
                        m_tdata  <= pipe;
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                        beat_cnt <= beat_cnt + 16'd1;
                        pipe     <= CH_DATA[int'(g_q)*DW +: DW];
                        pipe_vld <= CH_TRIGGERED[g_q];
                    end else begin
                        // trigger gone or beat limit hit: any remaining beats are discarded
                        state    <= ST_FTR;
                        pipe_vld <= 1'b0;
                        m_tdata  <= make_ftr(4'(g_q), beat_cnt, beat_cnt == MAX_CNT, lost_now);
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b1;
                    end
                end
                ST_FTR: begin
                    if (M_AXIS_TREADY) begin
                        state    <= ST_IDLE;
                        busy_q   <= 1'b0;
                        m_tdata  <= '0;
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign M_AXIS_TDATA  = m_tdata;
    assign M_AXIS_TVALID = m_tvalid;
    assign M_AXIS_TLAST  = m_tlast;
    assign BUSY          = busy_q;
    assign DROP_COUNT    = drop_count_q;

endmodule

// File: tb/tb_mm_trg_arbiter.sv
// Scoreboard bench for mm_trg_arbiter: stimulus pushes expected beats, a monitor pops them.
// A second instance with MAX_BEATS=4 is used for the truncation case.
module tb_mm_trg_arbiter;

    localparam int NC = 4;
    localparam int DW = 128;
`ifdef MM_ARB_FIXED_PRIO_EN
    localparam int SECOND_CH = 0;
`else
    localparam int SECOND_CH = 2;
`endif

    typedef struct {
        int           cyc;
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        exec_state = 2'b11;
    logic [NC-1:0]     trig = '0;
    logic [NC*DW-1:0]  ch_data = '0;
    logic [NC*44-1:0]  ch_ts = '0;
    logic [NC*12-1:0]  ch_bl = '0;
    logic              tready = 1'b1;
    logic [DW-1:0]     m_tdata, t_tdata;
    logic              m_tvalid, t_tvalid, m_tlast, t_tlast, m_busy, t_busy;
    logic [31:0]       m_drop, t_drop;
    logic              sel = 1'b0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;
    int   s;
    exp_t exp_q[$];
    exp_t last_exp;
    logic prev_stall = 1'b0;

    wire [DW-1:0] mon_data  = sel ? t_tdata  : m_tdata;
    wire          mon_valid = sel ? t_tvalid : m_tvalid;
    wire          mon_last  = sel ? t_tlast  : m_tlast;
    wire          mon_busy  = sel ? t_busy   : m_busy;
    wire [31:0]   mon_drop  = sel ? t_drop   : m_drop;

    mm_trg_arbiter #(.NUM_CH(NC), .MAX_BEATS(256)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .EXEC_STATE(exec_state),
        .CH_TRIGGERED(trig), .CH_DATA(ch_data), .CH_TIME_STAMP(ch_ts), .CH_BASELINE(ch_bl),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast),
        .M_AXIS_TREADY(tready), .BUSY(m_busy), .DROP_COUNT(m_drop));

    mm_trg_arbiter #(.NUM_CH(NC), .MAX_BEATS(4)) dut_t (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .EXEC_STATE(exec_state),
        .CH_TRIGGERED(trig), .CH_DATA(ch_data), .CH_TIME_STAMP(ch_ts), .CH_BASELINE(ch_bl),
        .M_AXIS_TDATA(t_tdata), .M_AXIS_TVALID(t_tvalid), .M_AXIS_TLAST(t_tlast),
        .M_AXIS_TREADY(tready), .BUSY(t_busy), .DROP_COUNT(t_drop));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] data_of(input int c, input int t);
        return {8'(c + 1), 8'hD0, 80'h0, 32'(t)};
    endfunction
    function automatic logic [43:0] ts_of(input int c, input int t);
        return {4'(c), 40'(t * 3)};
    endfunction
    function automatic logic [11:0] bl_of(input int c, input int t);
        return 12'(c * 256 + (t % 256));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            ch_data[c*DW +: DW] = data_of(c, cyc);
            ch_ts[c*44 +: 44]   = ts_of(c, cyc);
            ch_bl[c*12 +: 12]   = bl_of(c, cyc);
        end
    endtask

    // header at st+1, n data beats from st+2, footer at st+2+n (if with_ftr)
    task automatic push_frame(input int ch, input int st, input int n, input int cnt,
                              input logic trunc, input logic lost, input logic with_ftr);
        exp_t e;
        e.cyc  = st + 1;
        e.data = {8'hAA, 4'(ch), bl_of(ch, st), ts_of(ch, st), 60'b0};
        e.last = 1'b0;
        exp_q.push_back(e);
        for (int j = 0; j < n; j++) begin
            e.cyc  = st + 2 + j;
            e.data = data_of(ch, st + j);
            exp_q.push_back(e);
        end
        if (with_ftr) begin
            e.cyc  = st + 2 + n;
            e.data = {8'h55, 4'(ch), 16'(cnt), trunc, lost, 98'b0};
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        trig       = '0;
        tready     = 1'b1;
        exec_state = 2'b11;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((mon_busy || mon_valid) && n < 60) begin
            step();
            n++;
        end
        if (mon_busy || mon_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // monitor: pops one expected beat per new output beat; a stalled footer must hold
    always @(negedge clk) begin
        exp_t e;
        if (mon_valid) begin
            if (prev_stall) begin
                checks++;
                if (mon_data !== last_exp.data || mon_last !== 1'b1) begin
                    errors++;
                    $display("FAIL footer_hold cyc=%0d actual=%h required=%h", cyc, mon_data, last_exp.data);
                end
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat cyc=%0d actual=%h required=none", cyc, mon_data);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                checks++;
                if (mon_data !== e.data || mon_last !== e.last || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL beat actual=cyc%0d/%h/last%0b required=cyc%0d/%h/last%0b",
                             cyc, mon_data, mon_last, e.cyc, e.data, e.last);
                end
            end
            if (mon_last && !tready) stall_cnt++;
        end
        prev_stall = mon_valid && mon_last && !tready;
    end

    initial begin
        // reset state
        step();
        check("rst_tvalid", 64'(m_tvalid), 0);
        check("rst_tlast", 64'(m_tlast), 0);
        check("rst_tdata_zero", 64'(m_tdata != '0), 0);
        check("rst_busy", 64'(m_busy), 0);
        check("rst_drop", 64'(m_drop), 0);
        do_reset();

        // 1: single 5-beat frame from ch1
        for (int k = 0; k < 12; k++) begin
            step();
            trig = (k < 5) ? 4'b0010 : 4'b0000;
            if (k == 0) begin
                s = cyc;
                push_frame(1, s, 5, 5, 1'b0, 1'b0, 1'b1);
            end
            if (k == 3) check("t1_busy", 64'(mon_busy), 1);
        end
        wait_idle("t1");
        check("t1_drop", 64'(mon_drop), 0);

        // 2: ch0+ch2 simultaneous starts twice; second round one cycle after footer acceptance
        do_reset();
        for (int k = 0; k < 15; k++) begin
            step();
            trig = (k < 2 || k == 5 || k == 6) ? 4'b0101 : 4'b0000;
            if (k == 0) begin
                s = cyc;
                push_frame(0, s, 2, 2, 1'b0, 1'b0, 1'b1);
            end
            if (k == 5) push_frame(SECOND_CH, s + 5, 2, 2, 1'b0, 1'b0, 1'b1);
        end
        wait_idle("t2");
        check("t2_drop", 64'(mon_drop), 2);

        // 3: ch3 starts during ch1 data phase
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step();
            trig = {(k >= 3 && k < 8), 1'b0, (k < 6), 1'b0};
            if (k == 0) begin
                s = cyc;
                push_frame(1, s, 6, 6, 1'b0, 1'b0, 1'b1);
            end
        end
        wait_idle("t3");
        check("t3_drop", 64'(mon_drop), 1);

        // 4: truncation at MAX_BEATS=4, then a fresh frame after the trigger re-rises
        do_reset();
        sel = 1'b1;
        for (int k = 0; k < 21; k++) begin
            step();
            trig = (k < 10 || k == 12) ? 4'b0100 : 4'b0000;
            if (k == 0) begin
                s = cyc;
                push_frame(2, s, 4, 4, 1'b1, 1'b0, 1'b1);
            end
            if (k == 8) check("t4_idle_while_held", 64'(mon_busy), 0);
            if (k == 12) push_frame(2, s + 12, 1, 1, 1'b0, 1'b0, 1'b1);
        end
        wait_idle("t4");
        check("t4_drop", 64'(mon_drop), 0);
        do_reset();
        sel = 1'b0;

        // 5: backpressure on data (lost) and on footer (held)
        for (int k = 0; k < 15; k++) begin
            step();
            trig   = (k < 4) ? 4'b0100 : 4'b0000;
            tready = !(k == 3 || k == 4 || k == 6 || k == 7 || k == 8);
            if (k == 0) begin
                s = cyc;
                stall_cnt = 0;
                push_frame(2, s, 4, 4, 1'b0, 1'b1, 1'b1);
            end
        end
        wait_idle("t5");
        check("t5_footer_stall_cycles", 64'(stall_cnt), 3);

        // 6a: no grants outside TRG
        do_reset();
        exec_state = 2'b00;
        for (int k = 0; k < 6; k++) begin
            step();
            trig = (k < 3) ? 4'b0001 : 4'b0000;
            if (k == 2) check("t6_no_grant", 64'(mon_busy), 0);
        end
        // 6b: EXEC_STATE leaves TRG mid-frame
        exec_state = 2'b11;
        for (int k = 0; k < 13; k++) begin
            step();
            trig = (k < 4) ? 4'b0010 : 4'b0000;
            if (k == 0) begin
                s = cyc;
                push_frame(1, s, 4, 4, 1'b0, 1'b0, 1'b1);
            end
            if (k == 2) exec_state = 2'b00;
        end
        wait_idle("t6b");
        // 6c: reset mid-frame
        exec_state = 2'b11;
        step();
        trig = 4'b0100;
        s = cyc;
        push_frame(2, s, 1, 0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", 64'(m_tvalid), 0);
        check("t6_rst_busy", 64'(m_busy), 0);
        trig = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t6_after_rst_tvalid", 64'(m_tvalid), 0);
        check("t6_queue_empty", 64'(exp_q.size()), 0);

        // 7: start in the footer-acceptance cycle is dropped
        do_reset();
        for (int k = 0; k < 11; k++) begin
            step();
            trig = {2'b00, (k == 0), (k >= 3 && k < 6)};
            if (k == 0) begin
                s = cyc;
                push_frame(1, s, 1, 1, 1'b0, 1'b0, 1'b1);
            end
            if (k == 4) check("t7_idle_after_ftr", 64'(mon_busy), 0);
        end
        wait_idle("t7");
        check("t7_drop", 64'(mon_drop), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
